// File: rtl/mem_bus_pkg.sv
// ----------------------------------------------------------------------------
// mem_bus_pkg : types and constants shared by the memory stage and dmem_sram_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_bus_pkg;

  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } mem_state_e;

  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } mem_phase_e;

  // Expand a byte-select pair into a 16-bit half-word lane mask.
  function automatic logic [15:0] lane_mask(input logic [1:0] sel_pair);
    return {{8{sel_pair[1]}}, {8{sel_pair[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_sram_ctrl_if.sv
// ----------------------------------------------------------------------------
// dmem_sram_ctrl_if : memory-stage request/response bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dmem_sram_ctrl_if;
  import mem_bus_pkg::*;

  logic             mem_ena_i;
  logic             mem_w_r_i;
  logic [31:0]      mem_addr_i;
  logic [SEL_W-1:0] mem_sel_i;
  logic [31:0]      mem_data_i;
  logic [31:0]      mem_rdata_o;
  logic             mem_valid_o;

  modport master (
    output mem_ena_i, mem_w_r_i, mem_addr_i, mem_sel_i, mem_data_i,
    input  mem_rdata_o, mem_valid_o
  );

  modport slave (
    input  mem_ena_i, mem_w_r_i, mem_addr_i, mem_sel_i, mem_data_i,
    output mem_rdata_o, mem_valid_o
  );

endinterface

`default_nettype wire

// File: rtl/dmem_sram_ctrl_wait_cnt.sv
// ----------------------------------------------------------------------------
// sram_wait_cnt : strobe wait-state counter, load then count down to a last flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sram_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       last_o
);

  logic [3:0] cnt_q;

  // Saturates at zero so a stalled strobe never wraps into a long count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign last_o = (cnt_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/dmem_sram_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_sram_ctrl : CPU data-memory responder on a 16-bit asynchronous SRAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dmem_sram_ctrl
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_sram_ctrl_if.slave   bus,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe_o,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              sram_ub_n_o,
  output logic              sram_lb_n_o
);

  mem_state_e        state_q;
  mem_phase_e        phase_q;
  logic              w_r_q;
  logic [ADDR_W-2:0] addr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [31:0]       data_q;
  logic [31:0]       rbuf_q;
  logic [31:0]       rdata_q;
  logic              valid_q;
  logic [ADDR_W-1:0] saddr_q;
  logic [15:0]       dq_q;
  logic              dq_oe_q;
  logic              ce_n_q;
  logic              oe_n_q;
  logic              we_n_q;
  logic              ub_n_q;
  logic              lb_n_q;

  logic              w_last;
  logic              w_acc;
  logic              w_wr;
  logic [ADDR_W-2:0] w_addr;
  logic [SEL_W-1:0]  w_sel;
  logic [31:0]       w_data;
  mem_phase_e        w_phase;
  logic [1:0]        w_pair;
  logic [15:0]       w_half;
  logic [15:0]       w_cap;
  logic [31:0]       rbuf_d;
  logic              w_unused_addr;

  // Phase setup is taken from the bus on accept and from the latched request
  // when moving from LO into HI.
  assign w_acc   = (state_q == IDLE);
  assign w_wr    = w_acc ? bus.mem_w_r_i : w_r_q;
  assign w_addr  = w_acc ? bus.mem_addr_i[ADDR_W:2] : addr_q;
  assign w_sel   = w_acc ? bus.mem_sel_i : sel_q;
  assign w_data  = w_acc ? bus.mem_data_i : data_q;
  assign w_phase = (w_acc && (w_sel[1:0] != 2'b00)) ? PH_LO : PH_HI;
  assign w_pair  = (w_phase == PH_HI) ? w_sel[3:2] : w_sel[1:0];
  assign w_half  = (w_phase == PH_HI) ? w_data[31:16] : w_data[15:0];

  assign w_cap  = sram_dq_i & lane_mask((phase_q == PH_HI) ? sel_q[3:2] : sel_q[1:0]);
  assign rbuf_d = (phase_q == PH_HI) ? {w_cap, rbuf_q[15:0]} : {rbuf_q[31:16], w_cap};

  assign w_unused_addr = ^{bus.mem_addr_i[31:ADDR_W+1], bus.mem_addr_i[1:0]};

  sram_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == SETUP),
    .load_val_i (4'(WAIT_CYC - 1)),
    .dec_i      (state_q == STROBE),
    .last_o     (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= PH_LO;
      w_r_q   <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      saddr_q <= '0;
      dq_q    <= '0;
      dq_oe_q <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.mem_ena_i) begin
            w_r_q   <= w_wr;
            addr_q  <= w_addr;
            sel_q   <= w_sel;
            data_q  <= w_data;
            rbuf_q  <= '0;
            rdata_q <= '0;
            if (w_sel == '0) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= SETUP;
              phase_q <= w_phase;
              saddr_q <= {w_addr, w_phase};
              ub_n_q  <= ~w_pair[1];
              lb_n_q  <= ~w_pair[0];
              dq_oe_q <= w_wr;
              if (w_wr) dq_q <= w_half;
            end
          end
        end
        SETUP: begin
          state_q <= STROBE;
          ce_n_q  <= 1'b0;
          oe_n_q  <= w_r_q;
          we_n_q  <= ~w_r_q;
        end
        STROBE: begin
          if (w_last) begin
            if (!w_r_q) rbuf_q <= rbuf_d;
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
            if ((phase_q == PH_LO) && (sel_q[3:2] != 2'b00)) begin
              state_q <= SETUP;
              phase_q <= PH_HI;
              saddr_q <= {w_addr, w_phase};
              ub_n_q  <= ~w_pair[1];
              lb_n_q  <= ~w_pair[0];
              dq_oe_q <= w_wr;
              if (w_wr) dq_q <= w_half;
            end else begin
              state_q <= DONE;
              valid_q <= 1'b1;
              dq_oe_q <= 1'b0;
              rdata_q <= w_r_q ? 32'd0 : rbuf_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rdata_o = rdata_q;
  assign bus.mem_valid_o = valid_q;
  assign sram_addr_o     = saddr_q;
  assign sram_dq_o       = dq_q;
  assign sram_dq_oe_o    = dq_oe_q;
  assign sram_ce_n_o     = ce_n_q;
  assign sram_oe_n_o     = oe_n_q;
  assign sram_we_n_o     = we_n_q;
  assign sram_ub_n_o     = ub_n_q;
  assign sram_lb_n_o     = lb_n_q;

endmodule

`default_nettype wire
